// File: rtl/m_imem_loader.sv
// ---------------------------------------------------------------------------
// m_imem_loader
//
// Fills the processor's instruction RAM from a byte stream (typically a UART
// receiver) and holds the processor in reset until an image has loaded and
// its checksum has matched.
//
// Frame layout on the byte stream:
//   count[15:8] count[7:0] | word0 (4 bytes, MSB first) ... wordN-1 |
//   checksum (4 bytes, MSB first) = XOR of all N words (0 when N = 0)
//
// Ports:
//   w_clk       in   system clock, rising edge
//   w_rst       in   synchronous active-high reset
//   w_rx_data   in   received byte
//   w_rx_valid  in   one-cycle strobe qualifying w_rx_data (no backpressure)
//   r_mem_addr  out  RAM word address
//   r_mem_we    out  RAM write enable, one cycle per completed word
//   r_mem_din   out  RAM write data
//   r_proc_rst  out  processor reset, released only after a clean load
//   r_done      out  sticky: frame loaded and checksum matched
//   r_err       out  sticky: frame rejected (oversize count or bad checksum)
//   r_nwords    out  word count of the current or last frame
// ---------------------------------------------------------------------------
module m_imem_loader #(
    parameter int ADDR_W    = 11,
    parameter int MAX_WORDS = 2048,
    parameter int TIMEOUT   = 100000
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic [7:0]        w_rx_data,
    input  logic              w_rx_valid,
    output logic [ADDR_W-1:0] r_mem_addr,
    output logic              r_mem_we,
    output logic [31:0]       r_mem_din,
    output logic              r_proc_rst,
    output logic              r_done,
    output logic              r_err,
    output logic [15:0]       r_nwords
);

    localparam int                IDLE_W     = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);
    localparam logic [15:0]       MAX_COUNT  = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_SUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_byte_idx;
    logic [1:0]        w_byte_idx_nxt;
    logic [15:0]       r_word_idx;
    logic [15:0]       w_word_idx_nxt;
    logic [31:0]       r_xor;
    logic [31:0]       w_xor_nxt;
    logic [23:0]       r_asm;
    logic [23:0]       w_asm_nxt;
    logic [IDLE_W-1:0] r_idle;
    logic [IDLE_W-1:0] w_idle_nxt;

    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic              w_mem_we_nxt;
    logic [31:0]       w_mem_din_nxt;
    logic              w_proc_rst_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic [15:0]       w_nwords_nxt;

    // Only the top three bytes of a word need storing: the fourth byte is
    // taken straight from the input on the cycle the word completes.
    logic [31:0] w_word;
    logic [15:0] w_count;
    logic        w_idle_run;
    logic        w_timeout;

    assign w_word     = {r_asm, w_rx_data};
    assign w_count    = {r_nwords[15:8], w_rx_data};
    assign w_idle_run = (r_state == S_CNT_LO) || (r_state == S_DATA) ||
                        (r_state == S_SUM);
    // The timeout takes priority over a byte arriving in the same cycle,
    // so that byte is dropped along with the partial frame.
    assign w_timeout  = w_idle_run && (r_idle == IDLE_LIMIT);

    // Next-state and next-output logic. Every register holds by default;
    // the write strobe defaults low so it can only pulse for one cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_byte_idx_nxt = r_byte_idx;
        w_word_idx_nxt = r_word_idx;
        w_xor_nxt      = r_xor;
        w_asm_nxt      = r_asm;
        w_idle_nxt     = r_idle;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_we_nxt   = 1'b0;
        w_mem_din_nxt  = r_mem_din;
        w_proc_rst_nxt = r_proc_rst;
        w_done_nxt     = r_done;
        w_err_nxt      = r_err;
        w_nwords_nxt   = r_nwords;

        if (w_timeout) begin
            // Abandon the partial frame; RAM contents and r_nwords are kept
            // and the next frame simply overwrites them.
            w_state_nxt    = S_CNT_HI;
            w_byte_idx_nxt = 2'd0;
            w_word_idx_nxt = 16'd0;
            w_xor_nxt      = 32'd0;
            w_asm_nxt      = 24'd0;
            w_idle_nxt     = '0;
        end else begin
            case (r_state)
                S_CNT_HI: begin
                    w_idle_nxt = '0;
                    if (w_rx_valid) begin
                        w_nwords_nxt = {w_rx_data, r_nwords[7:0]};
                        w_state_nxt  = S_CNT_LO;
                    end
                end

                S_CNT_LO: begin
                    if (w_rx_valid) begin
                        w_idle_nxt   = '0;
                        w_nwords_nxt = w_count;
                        if (w_count > MAX_COUNT) begin
                            w_state_nxt = S_ERR;
                            w_err_nxt   = 1'b1;
                        end else if (w_count == 16'd0) begin
                            w_state_nxt = S_SUM;
                        end else begin
                            w_state_nxt = S_DATA;
                        end
                    end else begin
                        w_idle_nxt = r_idle + IDLE_ONE;
                    end
                end

                S_DATA: begin
                    if (w_rx_valid) begin
                        w_idle_nxt     = '0;
                        w_asm_nxt      = w_word[23:0];
                        w_byte_idx_nxt = r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            w_mem_we_nxt   = 1'b1;
                            w_mem_addr_nxt = r_word_idx[ADDR_W-1:0];
                            w_mem_din_nxt  = w_word;
                            w_xor_nxt      = r_xor ^ w_word;
                            w_word_idx_nxt = r_word_idx + 16'd1;
                            if (r_word_idx == r_nwords - 16'd1) begin
                                w_state_nxt = S_SUM;
                            end
                        end
                    end else begin
                        w_idle_nxt = r_idle + IDLE_ONE;
                    end
                end

                S_SUM: begin
                    if (w_rx_valid) begin
                        w_idle_nxt     = '0;
                        w_asm_nxt      = w_word[23:0];
                        w_byte_idx_nxt = r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            if (w_word == r_xor) begin
                                w_state_nxt    = S_DONE;
                                w_done_nxt     = 1'b1;
                                w_proc_rst_nxt = 1'b0;
                            end else begin
                                w_state_nxt = S_ERR;
                                w_err_nxt   = 1'b1;
                            end
                        end
                    end else begin
                        w_idle_nxt = r_idle + IDLE_ONE;
                    end
                end

                // Terminal states: everything holds until reset.
                S_DONE: begin
                    w_idle_nxt = '0;
                end

                S_ERR: begin
                    w_idle_nxt = '0;
                end

                default: begin
                    w_state_nxt = S_CNT_HI;
                end
            endcase
        end
    end

    // State and output registers. Reset wins over everything, including a
    // write strobe that would otherwise have been issued this cycle.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state    <= S_CNT_HI;
            r_byte_idx <= 2'd0;
            r_word_idx <= 16'd0;
            r_xor      <= 32'd0;
            r_asm      <= 24'd0;
            r_idle     <= '0;
            r_mem_addr <= '0;
            r_mem_we   <= 1'b0;
            r_mem_din  <= 32'd0;
            r_proc_rst <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_nwords   <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_word_idx <= w_word_idx_nxt;
            r_xor      <= w_xor_nxt;
            r_asm      <= w_asm_nxt;
            r_idle     <= w_idle_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_we   <= w_mem_we_nxt;
            r_mem_din  <= w_mem_din_nxt;
            r_proc_rst <= w_proc_rst_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_nwords   <= w_nwords_nxt;
        end
    end

endmodule

// File: tb/tb_m_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_m_imem_loader
//
// Testbench for m_imem_loader (built with TIMEOUT = 16). Frames are held in a
// byte queue; a frame-level reference model derives the expected RAM writes
// and the final done/err/count outcome, and a monitor collects every write
// strobe the loader actually issues.
// ---------------------------------------------------------------------------
module tb_m_imem_loader;

    localparam int ADDR_W    = 11;
    localparam int MAX_WORDS = 2048;
    localparam int TIMEOUT   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_din;
    logic              proc_rst;
    logic              done;
    logic              err;
    logic [15:0]       nwords;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]        frame_q[$];
    logic [ADDR_W-1:0] got_addr[$];
    logic [31:0]       got_data[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    logic              exp_done;
    logic              exp_err;
    logic [15:0]       exp_nwords;

    m_imem_loader #(
        .ADDR_W   (ADDR_W),
        .MAX_WORDS(MAX_WORDS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .w_clk     (clk),
        .w_rst     (rst),
        .w_rx_data (rx_data),
        .w_rx_valid(rx_valid),
        .r_mem_addr(mem_addr),
        .r_mem_we  (mem_we),
        .r_mem_din (mem_din),
        .r_proc_rst(proc_rst),
        .r_done    (done),
        .r_err     (err),
        .r_nwords  (nwords)
    );

    always #5 clk = ~clk;

    // Collect every write strobe, sampled half a cycle after the edge.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_din);
        end
    end

    // Present one byte for exactly one cycle. Called at a negedge; returns
    // at the next negedge, when the loader's response to it is visible.
    task automatic applyStimulus(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        got_addr.delete();
        got_data.delete();
    endtask

    // Frame-level reference: interpret frame_q as count, words, checksum.
    task automatic model_frame();
        logic [15:0] n;
        logic [31:0] w;
        logic [31:0] cs;
        logic [31:0] sum;
        int          base;
        exp_addr.delete();
        exp_data.delete();
        exp_done   = 1'b0;
        exp_err    = 1'b0;
        n          = {frame_q[0], frame_q[1]};
        exp_nwords = n;
        if (int'(n) > MAX_WORDS) begin
            exp_err = 1'b1;
            return;
        end
        cs = 32'd0;
        for (int k = 0; k < int'(n); k++) begin
            base = 2 + 4 * k;
            w = {frame_q[base], frame_q[base+1], frame_q[base+2], frame_q[base+3]};
            exp_addr.push_back(ADDR_W'(k));
            exp_data.push_back(w);
            cs = cs ^ w;
        end
        base = 2 + 4 * int'(n);
        sum  = {frame_q[base], frame_q[base+1], frame_q[base+2], frame_q[base+3]};
        if (sum == cs) exp_done = 1'b1;
        else           exp_err  = 1'b1;
    endtask

    // Build a random frame of n words; optionally corrupt the checksum and
    // append junk bytes that must be ignored once the frame has ended.
    task automatic build_random_frame(input int n, input bit corrupt, input int junk);
        logic [31:0] w;
        logic [31:0] cs;
        frame_q.delete();
        frame_q.push_back(8'(n >> 8));
        frame_q.push_back(8'(n));
        cs = 32'd0;
        for (int k = 0; k < n; k++) begin
            w  = $urandom;
            cs = cs ^ w;
            for (int b = 3; b >= 0; b--) frame_q.push_back(w[b*8 +: 8]);
        end
        if (corrupt) cs = cs ^ (32'd1 << $urandom_range(31, 0));
        for (int b = 3; b >= 0; b--) frame_q.push_back(cs[b*8 +: 8]);
        for (int j = 0; j < junk; j++) frame_q.push_back(8'($urandom));
    endtask

    // Scenario: send whatever frame_q holds with random gaps, then compare
    // the collected writes and final status against the reference model.
    task automatic test_frame(input string name, input int gap_lo, input int gap_hi);
        model_frame();
        foreach (frame_q[i]) begin
            applyStimulus(frame_q[i]);
            idle($urandom_range(gap_hi, gap_lo));
        end
        idle(3);
        n_checks++;
        if (got_addr.size() !== exp_addr.size())
            $display("[TB] FAIL %s write_count: got %0d expected %0d", name, got_addr.size(), exp_addr.size());
        else n_pass++;
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            n_checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i])
                $display("[TB] FAIL %s write[%0d]: got (%0d,%h) expected (%0d,%h)",
                         name, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            else n_pass++;
        end
        n_checks++;
        if ({done, err, proc_rst} !== {exp_done, exp_err, ~exp_done})
            $display("[TB] FAIL %s status done/err/proc_rst: got %b%b%b expected %b%b%b",
                     name, done, err, proc_rst, exp_done, exp_err, ~exp_done);
        else n_pass++;
        n_checks++;
        if (nwords !== exp_nwords)
            $display("[TB] FAIL %s nwords: got %h expected %h", name, nwords, exp_nwords);
        else n_pass++;
    endtask

    task automatic test_reset();
        // Feed bytes while reset is held: nothing may leave reset state.
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(8'($urandom));
        rst = 1'b0;
        n_checks++;
        if (mem_addr !== '0 || mem_we !== 1'b0 || mem_din !== 32'd0)
            $display("[TB] FAIL reset mem_port: got (%0d,%b,%h) expected (0,0,00000000)", mem_addr, mem_we, mem_din);
        else n_pass++;
        n_checks++;
        if ({proc_rst, done, err} !== 3'b100)
            $display("[TB] FAIL reset status proc_rst/done/err: got %b%b%b expected 100", proc_rst, done, err);
        else n_pass++;
        n_checks++;
        if (nwords !== 16'd0)
            $display("[TB] FAIL reset nwords: got %h expected 0000", nwords);
        else n_pass++;
    endtask

    task automatic test_spec_frame();
        do_reset();
        frame_q = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05,
                    8'h10, 8'h00, 8'hFF, 8'hFF, 8'h34, 8'h01, 8'hFF, 8'hFA};
        model_frame();
        foreach (frame_q[i]) begin
            applyStimulus(frame_q[i]);
            if (i == 5 || i == 9) begin
                n_checks++;
                if (mem_we !== 1'b1 || mem_addr !== exp_addr[(i-5)/4] || mem_din !== exp_data[(i-5)/4])
                    $display("[TB] FAIL spec write_timing[%0d]: got (%b,%0d,%h) expected (1,%0d,%h)",
                             i, mem_we, mem_addr, mem_din, exp_addr[(i-5)/4], exp_data[(i-5)/4]);
                else n_pass++;
                @(negedge clk);
                n_checks++;
                if (mem_we !== 1'b0)
                    $display("[TB] FAIL spec we_one_cycle[%0d]: got %b expected 0", i, mem_we);
                else n_pass++;
                idle(1);
            end else if (i == 13) begin
                n_checks++;
                if ({done, proc_rst, err} !== 3'b100)
                    $display("[TB] FAIL spec done_latency done/proc_rst/err: got %b%b%b expected 100", done, proc_rst, err);
                else n_pass++;
                idle(2);
            end else begin
                if (i == 12) begin
                    n_checks++;
                    if (done !== 1'b0)
                        $display("[TB] FAIL spec early_done: got %b expected 0", done);
                    else n_pass++;
                end
                idle(2);
            end
        end
        n_checks++;
        if (got_addr.size() !== 2)
            $display("[TB] FAIL spec write_count: got %0d expected 2", got_addr.size());
        else n_pass++;
        n_checks++;
        if (nwords !== exp_nwords)
            $display("[TB] FAIL spec nwords: got %h expected %h", nwords, exp_nwords);
        else n_pass++;
    endtask

    task automatic test_bad_checksum();
        do_reset();
        frame_q = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05,
                    8'h10, 8'h00, 8'hFF, 8'hFF, 8'h34, 8'h01, 8'hFF, 8'hFB};
        test_frame("bad_checksum", 2, 2);
    endtask

    task automatic test_zero_frame();
        do_reset();
        frame_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hA5};
        test_frame("zero_frame", 0, 3);
    endtask

    task automatic test_count_limit();
        do_reset();
        applyStimulus(8'h08);
        idle(1);
        applyStimulus(8'h01);
        n_checks++;
        if ({err, proc_rst, done} !== 3'b110)
            $display("[TB] FAIL oversize err_latency err/proc_rst/done: got %b%b%b expected 110", err, proc_rst, done);
        else n_pass++;
        for (int i = 0; i < 10; i++) applyStimulus(8'($urandom));
        idle(2);
        n_checks++;
        if (got_addr.size() !== 0 || err !== 1'b1 || done !== 1'b0 || nwords !== 16'h0801)
            $display("[TB] FAIL oversize ignore: got writes=%0d err=%b done=%b nwords=%h expected 0,1,0,0801",
                     got_addr.size(), err, done, nwords);
        else n_pass++;
        // Exactly MAX_WORDS is accepted.
        do_reset();
        applyStimulus(8'h08);
        applyStimulus(8'h00);
        n_checks++;
        if (err !== 1'b0 || nwords !== 16'h0800)
            $display("[TB] FAIL max_count accept: got err=%b nwords=%h expected 0,0800", err, nwords);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        applyStimulus(8'h00);
        idle(2);
        applyStimulus(8'h01);
        idle(2);
        applyStimulus(8'hAA);
        idle(20);
        n_checks++;
        if (err !== 1'b0 || done !== 1'b0 || nwords !== 16'h0001 || got_addr.size() !== 0)
            $display("[TB] FAIL timeout abandon: got err=%b done=%b nwords=%h writes=%0d expected 0,0,0001,0",
                     err, done, nwords, got_addr.size());
        else n_pass++;
        frame_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44};
        test_frame("timeout_reload", 0, 3);
        // Gaps well under the timeout must not disturb a frame.
        do_reset();
        build_random_frame(3, 1'b0, 0);
        test_frame("long_gaps", 10, 12);
    endtask

    task automatic test_reset_midframe();
        do_reset();
        applyStimulus(8'h00);
        applyStimulus(8'h02);
        applyStimulus(8'hDE);
        applyStimulus(8'hAD);
        rst = 1'b1;
        applyStimulus(8'hBE);
        rst = 1'b0;
        n_checks++;
        if (mem_addr !== '0 || mem_we !== 1'b0 || mem_din !== 32'd0 ||
            {proc_rst, done, err} !== 3'b100 || nwords !== 16'd0)
            $display("[TB] FAIL midframe_reset outputs: got addr=%0d we=%b din=%h pr/d/e=%b%b%b nwords=%h expected reset values",
                     mem_addr, mem_we, mem_din, proc_rst, done, err, nwords);
        else n_pass++;
        idle(3);
        n_checks++;
        if (got_addr.size() !== 0)
            $display("[TB] FAIL midframe_reset no_write: got %0d writes expected 0", got_addr.size());
        else n_pass++;
        build_random_frame(2, 1'b0, 2);
        test_frame("after_reset", 0, 2);
    endtask

    task automatic test_back_to_back();
        do_reset();
        build_random_frame(5, 1'b0, 4);
        test_frame("back_to_back", 0, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            do_reset();
            build_random_frame($urandom_range(6, 1), ($urandom_range(3, 0) == 0), $urandom_range(3, 0));
            test_frame("random", 0, 4);
        end
    endtask

    initial begin
        test_reset();
        test_spec_frame();
        test_bad_checksum();
        test_zero_frame();
        test_count_limit();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/m_imem_loader.md
Name: m_imem_loader

Overview:
- Writer-side counterpart to the processor's instruction-memory read port: fills the instruction RAM from a byte stream (e.g. a UART receiver) before the processor runs.
- Parses a framed image: 16-bit word count, then big-endian 32-bit words, then a 32-bit XOR checksum.
- Drives the RAM's (addr, we, din) write port and holds the processor in reset until a frame loads cleanly.

Parameters:
- ADDR_W, 11, word-address width of the instruction RAM (2048 words).
- MAX_WORDS, 2048, largest accepted word count.
- TIMEOUT, 100000, maximum idle cycles between bytes inside a frame before the frame is abandoned.

Ports:
- w_clk  input  1  system clock; all logic on the rising edge.
- w_rst  input  1  synchronous, active-high reset.
- w_rx_data  input  8  received byte.
- w_rx_valid  input  1  one-cycle strobe; w_rx_data is valid this cycle. No backpressure.
- r_mem_addr  output  ADDR_W  RAM word address.
- r_mem_we  output  1  RAM write enable.
- r_mem_din  output  32  RAM write data.
- r_proc_rst  output  1  holds the processor in reset while high.
- r_done  output  1  sticky; frame loaded and checksum matched.
- r_err  output  1  sticky; frame rejected.
- r_nwords  output  16  word count of the current or last frame.

Behaviour:
- Reset values:
  - r_mem_addr=0, r_mem_we=0, r_mem_din=0.
  - r_proc_rst=1, r_done=0, r_err=0, r_nwords=0.
  - State S_CNT_HI; byte index, word index, running XOR and idle counter all 0.
- States:
  - S_CNT_HI: a valid byte becomes r_nwords[15:8] -> S_CNT_LO.
  - S_CNT_LO: a valid byte becomes r_nwords[7:0].
    - If the 16-bit count > MAX_WORDS -> S_ERR.
    - Else if count==0 -> S_SUM.
    - Else -> S_DATA.
  - S_DATA: bytes shift into a 32-bit assembly register, MSB first.
    - On the 4th byte of word k, the next cycle has r_mem_we=1, r_mem_addr=k, r_mem_din=word, and the XOR accumulator takes the word.
    - After word N-1 -> S_SUM.
  - S_SUM: 4 bytes, MSB first, are compared to the XOR accumulator.
    - Equal -> S_DONE.
    - Else -> S_ERR.
  - S_DONE: r_done=1, r_proc_rst=0. All further w_rx_valid is ignored.
  - S_ERR: r_err=1, r_proc_rst stays 1. Bytes are ignored.
  - S_DONE and S_ERR leave only via w_rst.
- Write strobe:
  - r_mem_we is high exactly one cycle per word and never outside S_DATA completions.
  - Back-to-back word completions 4 cycles apart each produce a one-cycle write.
- Checksum: XOR of all N data words; checksum for N=0 is 0.
- Timeout:
  - The idle counter runs in S_CNT_LO, S_DATA and S_SUM, and clears on every valid byte.
  - When it reaches TIMEOUT, the partial frame is discarded and state returns to S_CNT_HI.
  - Indices and accumulator clear; r_nwords is kept; r_err is not set.
  - Words already written stay in RAM; a new frame overwrites them.
- Simultaneous events:
  - w_rst wins over everything. Reset mid-frame aborts immediately, and no write strobe is issued on the reset cycle or after it.
  - A valid byte arriving on the cycle the timeout fires is dropped.
- Width rules:
  - Word index is 16 bits; r_mem_addr = word index [ADDR_W-1:0].
  - MAX_WORDS guarantees no address wrap.
- Addressing latency: one cycle from the last data byte to the write strobe; r_done one cycle after the last checksum byte.

Test Plan:
- Frame 00 02 | 24 01 00 05 | 10 00 FF FF | 34 01 FF FA, one byte every 3 cycles -> writes (0,24010005) then (1,1000FFFF); r_done=1 and r_proc_rst=0 one cycle after the final byte; r_err=0; r_nwords=2.
- Same frame with last checksum byte FB -> both writes occur; r_err=1; r_proc_rst stays 1; r_done=0.
- Frame 00 00 00 00 00 00 -> no writes; r_done=1.
- Count bytes 08 01 (2049) -> r_err=1 one cycle after the 2nd byte; no writes; subsequent bytes ignored.
- With TIMEOUT=16:
  - Send 00 01 AA, then idle 20 cycles -> state back to S_CNT_HI, no r_err.
  - Then a full valid 1-word frame 00 01 11 22 33 44 11 22 33 44 -> write (0,11223344); r_done=1.
- Assert w_rst for one cycle after 2 data bytes of a word -> all outputs at reset values; no write strobe; a full frame afterwards loads normally.
